// File: rtl/apb3_s_mem_pkg.sv
// Shared types, default parameters and address decode helper for the APB3 register memory.
package apb3_s_mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 0;
  localparam int unsigned CNT_WIDTH       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/apb3_s_mem_array.sv
// DEPTH x DATA_WIDTH word storage: async clear, byte-enable write port, combinational read port.
module apb3_s_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb3_s_mem.sv
// APB3 completer with a small word-addressed memory, programmable wait states and error response.
// Optional per-lane write strobes: define APB3_S_MEM_PSTRB_EN.
module apb3_s_mem
  import apb3_s_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned           STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned           DEPTH       = DEF_DEPTH,
  parameter int unsigned           WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned ALIGN = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SPAN  = DEPTH * STRB_WIDTH;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  err_q;

  logic                  ready;
  logic                  latch;
  logic                  err_in;
  logic                  we;
  logic [STRB_WIDTH-1:0] wbe;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rdata;

  assign err_in = !addr_in_range(64'(PADDR), 64'(BASE_ADDR), 64'(SPAN)) ||
                  ((64'(PADDR) & 64'(STRB_WIDTH - 1)) != 64'd0);

  assign ready = (state == ACCESS) && (cnt == CNT_WIDTH'(WAIT_CYCLES));
  // A new setup phase is accepted from IDLE or on the completion edge of the current access.
  assign latch = PSELx && !PENABLE && ((state == IDLE) || ready);
  assign idx   = IDX_W'((64'(addr_q) - 64'(BASE_ADDR)) >> ALIGN);

`ifdef APB3_S_MEM_PSTRB_EN
  assign wbe = strb_q;
`else
  // Strobes are still latched but every lane is written.
  assign wbe = strb_q | {STRB_WIDTH{1'b1}};
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (PSELx && !PENABLE) state_nxt = SETUP;
      SETUP:   if (!PSELx) state_nxt = IDLE;
               else if (PENABLE) state_nxt = ACCESS;
      ACCESS:  if (ready) state_nxt = (PSELx && !PENABLE) ? SETUP : IDLE;
               else if (!PSELx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && err_q;
    we      = ready && write_q && !err_q;
    PRDATA  = (ready && !write_q && !err_q) ? rdata : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (state == SETUP && state_nxt == ACCESS) begin
      cnt <= '0;
    end else if (state == ACCESS && !ready) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else if (latch) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
      err_q   <= err_in;
    end
  end

  apb3_s_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (we),
    .be    (wbe),
    .waddr (idx),
    .wdata (wdata_q),
    .raddr (idx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_apb3_s_mem.sv
// Scoreboard bench for apb3_s_mem: driver queues expected responses, a negedge monitor checks each completion.
module tb_apb3_s_mem;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 16;
  localparam int WAIT  = 2;

`ifdef APB3_S_MEM_PSTRB_EN
  localparam logic [31:0] EXP_STRB  = 32'hFF34_FF78;
  localparam logic [31:0] EXP_STRB0 = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_STRB  = 32'h1234_5678;
  localparam logic [31:0] EXP_STRB0 = 32'h1111_1111;
`endif

  logic          PCLK, PRESETn, PSELx, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          id;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp, n_bad, n_id, wcnt;
  bit   mon_off;

  apb3_s_mem #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STRB_WIDTH  (SW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT),
    .BASE_ADDR   ('0)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (xfer %0d): got 0x%08h, required 0x%08h", name, id, act, exp);
    end
  endtask

  // The completer's SETUP state overlaps the first enabled bus cycle, so the bus sees WAIT+1 low cycles.
  always @(negedge PCLK) begin
    if (mon_off || !PSELx || !PENABLE) begin
      wcnt = 0;
    end else if (!PREADY) begin
      wcnt++;
    end else begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", -1, 32'(PREADY), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("prdata", mon_e.id, PRDATA, mon_e.rd);
        chk("pslverr", mon_e.id, 32'(PSLVERR), 32'(mon_e.err));
        chk("wait_cycles", mon_e.id, 32'(wcnt), 32'(WAIT + 1));
      end
      wcnt = 0;
    end
  end

  task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    #1;
    PSELx   = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = w;
    PADDR   = a;
    PWDATA  = d;
    PSTRB   = s;
  endtask

  // Raise PENABLE, scramble the bus fields, then wait for PREADY; returns on the completion negedge.
  task automatic finish(input int id);
    bit got;
    got = 1'b0;
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    PADDR   = 32'hFFFF_FFF0;
    PWDATA  = 32'hA5A5_5A5A;
    PWRITE  = ~PWRITE;
    PSTRB   = ~PSTRB;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge PCLK);
      got = PREADY;
    end
    if (!got) chk("ready_timeout", id, 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] erd, input logic eerr);
    exp_t e;
    e.rd  = erd;
    e.err = eerr;
    e.id  = n_id;
    n_id++;
    sbq.push_back(e);
    start(w, a, d, s);
    finish(e.id);
  endtask

  task automatic idle(input int n);
    #1;
    PSELx   = 1'b0;
    PENABLE = 1'b0;
    repeat (n) @(posedge PCLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; n_id = 0; wcnt = 0; mon_off = 1'b0;
    PRESETn = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    #2 PRESETn = 1'b0;
    #10;
    chk("reset_pready", -1, 32'(PREADY), 32'd0);
    chk("reset_pslverr", -1, 32'(PSLVERR), 32'd0);
    chk("reset_prdata", -1, PRDATA, 32'd0);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    idle(2);

    xfer(0, 32'h08, 32'h0, 4'hF, 32'h0, 1'b0);                idle(1);
    xfer(1, 32'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);        idle(1);
    xfer(0, 32'h04, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);        idle(1);
    xfer(1, 32'h40, 32'h0000_0055, 4'hF, 32'h0, 1'b1);        idle(1);
    xfer(0, 32'h00, 32'h0, 4'hF, 32'h0, 1'b0);                idle(1);
    xfer(0, 32'h02, 32'h0, 4'hF, 32'h0, 1'b1);                idle(1);
    xfer(1, 32'h3C, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h3C, 32'h0, 4'hF, 32'hA5A5_0F0F, 1'b0);        idle(1);

    xfer(1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    xfer(1, 32'h0C, 32'h1234_5678, 4'b0101, 32'h0, 1'b0);
    xfer(0, 32'h0C, 32'h0, 4'hF, EXP_STRB, 1'b0);             idle(1);
    xfer(1, 32'h08, 32'h1111_1111, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h08, 32'h0, 4'hF, EXP_STRB0, 1'b0);            idle(1);

    xfer(1, 32'h10, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h10, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
    xfer(0, 32'h44, 32'h0, 4'hF, 32'h0, 1'b1);
    xfer(0, 32'h04, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);        idle(1);

    // Abort: PSELx drops in ACCESS before the wait states expire.
    start(1, 32'h18, 32'h0BAD_F00D, 4'hF);
    @(posedge PCLK);
    #1 PENABLE = 1'b1;
    @(posedge PCLK);
    #1 PSELx = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("abort_pready", -1, 32'(PREADY), 32'd0);
    idle(1);
    xfer(0, 32'h18, 32'h0, 4'hF, 32'h0, 1'b0);                idle(1);

    // Reset while the completer is presenting PREADY on a write.
    mon_off = 1'b1;
    start(1, 32'h14, 32'h7777_7777, 4'hF);
    finish(-2);
    chk("pre_reset_pready", -2, 32'(PREADY), 32'd1);
    #1 PRESETn = 1'b0;
    #1;
    chk("rst_async_pready", -2, 32'(PREADY), 32'd0);
    chk("rst_async_pslverr", -2, 32'(PSLVERR), 32'd0);
    PSELx = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    mon_off = 1'b0;
    idle(1);
    xfer(0, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h0C, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h14, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h3C, 32'h0, 4'hF, 32'h0, 1'b0);                idle(3);

    chk("scoreboard_drain", -1, 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
